mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the 5-stage RISC-V pipeline. Consumes the EX/MEM register outputs of the execute stage. Runs loads and stores against a req/ack data-memory bus, with byte-lane steering, load sign/zero extension and misalignment detection. Stalls the upstream pipeline while a bus access is outstanding, then registers results into MEM/WB and drives `resultW` back for writeback and forwarding.

## Interface
- `TIMEOUT_CYCLES`, 16: wait cycles before a bus access is aborted. Used only with `MEM_TIMEOUT_EN`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `regwriteM` in 1: instruction writes rd.
- `memrwM` in 1: 1 = store.
- `wbselM` in 2: writeback select. 00 ALU, 01 load data, 10 pc+4, 11 ALU.
- `funct3M` in 3: access size/sign.
- `ALUresM` in 32: effective address / ALU result.
- `data_writeM` in 32: store data.
- `rdM` in 5: destination register.
- `pc4M` in 32: pc+4.
- `dmem_req` out 1: bus request.
- `dmem_we` out 1: bus write.
- `dmem_addr` out 32: word-aligned address, `{ALUresM[31:2],2'b00}`.
- `dmem_wdata` out 32: lane-steered store data.
- `dmem_be` out 4: byte enables.
- `dmem_rdata` in 32: read data, valid with ack.
- `dmem_ack` in 1: access complete.
- `stallM` out 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- `regwriteW`, `wbselW`, `rdW`, `ALUresW`, `pc4W`, `read_dataW` out (1/2/5/32/32/32): MEM/WB register.
- `misalignW` out 1: registered misaligned-access flag.
- `bus_errW` out 1: registered timeout flag. Constant 0 without `MEM_TIMEOUT_EN`.
- `resultW` out 32: writeback mux of W registers.

## Operation
- Load = `wbselM==01 && !memrwM`. Store = `memrwM`. Access = load or store.
- Misaligned: halfword with `addr[0]`, or word with `addr[1:0]!=0`.
  - No bus request is issued.
  - `misalignW` is set and `regwriteW` is forced 0.
  - Completes in one cycle.
- Store steering:
  - SB: be=`0001<<addr[1:0]`, data = byte replicated ×4.
  - SH: be=`0011<<addr[1:0]`, data = half replicated ×2.
  - SW: be=`1111`.
  - `dmem_be` is `0000` on loads. Stores with funct3 other than 000/001/010 perform no access and are treated as a NOP.
- Load extract from `dmem_rdata` by `addr[1:0]`:
  - LB/LH are sign-extended. LBU/LHU are zero-extended. LW is passed through.
  - Any other funct3 returns 0.
- FSM states: IDLE, WAIT.
  - IDLE with a valid access: `dmem_req`=1 combinationally the same cycle.
    - If `dmem_ack`: complete, stay in IDLE.
    - Else: go to WAIT.
  - WAIT: hold `dmem_req` with stable addr/we/be/wdata (inputs are frozen by `stallM`). On `dmem_ack`, complete and return to IDLE.
- `stallM` = access pending and not acked this cycle, in either state. Combinational.
- MEM/WB update every cycle:
  - Completing or non-access cycle: capture the M inputs and the extracted load data.
  - Stall cycle: insert a bubble. `regwriteW`=0 and `rdW`=0; other W fields hold.
- `resultW`:
  - `wbselW` 01 → `read_dataW`.
  - 10 → `pc4W`.
  - otherwise → `ALUresW`.
- `dmem_ack` in IDLE with no request is ignored.

## Timing
- Reset: FSM IDLE; all W outputs, `misalignW` and `bus_errW` are 0, so `resultW`=0. `dmem_req` drops immediately and asynchronously. Reset mid-WAIT abandons the access; a late ack is ignored.
- Zero-wait ack: `stallM` is never high. W registers update on the next edge.
- N wait cycles:
  - `dmem_req` is high N+1 cycles; `stallM` is high N cycles.
  - N bubbles enter W.
  - Data is captured on the edge where ack is high.
- Non-access instructions: 1-cycle pass-through to W.

## Configuration
- `MEM_TIMEOUT_EN` defined: a 16-bit wait counter increments in WAIT and clears on leaving WAIT.
  - When the count reaches `TIMEOUT_CYCLES` without ack, the access is aborted: `dmem_req` drops, the FSM returns to IDLE, `stallM` deasserts.
  - W captures with `bus_errW`=1 and `regwriteW` forced 0.
  - An ack arriving on the same cycle as the timeout wins.
- Not defined: no counter. WAIT persists until ack and `bus_errW` is tied 0.

## Test plan
- LB from addr 0x1003, ack same cycle, rdata 0x80FF_FF12 → `regwriteW`=1, `read_dataW`=0xFFFF_FF80, `resultW`=0xFFFF_FF80, `stallM` never 1.
- SH data 0x0000_ABCD to addr 0x2002, ack after 3 cycles → `dmem_be`=1100, wdata 0xABCD_ABCD, `dmem_req` high 4 cycles, `stallM` high 3, 3 bubbles (`regwriteW`=0).
- LW to addr 0x3001 → no `dmem_req`, `misalignW`=1, `regwriteW`=0, no stall.
- Non-access (wbsel 10, pc4M 0x104) → `resultW`=0x104 one cycle later. Spurious `dmem_ack` has no effect.
- Assert `rst_n`=0 mid-WAIT → `dmem_req` and all outputs 0 immediately; after release, a late ack is ignored and the next LW completes normally.
- `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, no ack → abort after 16 WAIT cycles, `bus_errW`=1, `regwriteW`=0, `stallM` released. Repeat with ack on cycle 16 → normal completion, `bus_errW`=0.

Source files
------------

// File: rtl/mem_access_if.sv
// Data-memory req/ack bus between the memory-access stage and data memory.
// Master drives the request side; slave returns read data and ack.
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage of the 5-stage RISC-V pipeline.
// Issues loads/stores on a req/ack bus with byte-lane steering, load
// extension and misalignment detection, stalls upstream while an access is
// outstanding, and registers results into MEM/WB.
// Optional feature: define MEM_TIMEOUT_EN to abort bus accesses that wait
// TIMEOUT_CYCLES cycles in WAIT without an ack (reported on bus_errW).
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  // EX/MEM register
  input  logic                regwriteM,
  input  logic                memrwM,
  input  logic [1:0]          wbselM,
  input  logic [2:0]          funct3M,
  input  logic [31:0]         ALUresM,
  input  logic [31:0]         data_writeM,
  input  logic [4:0]          rdM,
  input  logic [31:0]         pc4M,
  // data-memory bus
  mem_access_if.master        dmem,
  // pipeline control
  output logic                stallM,
  // MEM/WB register
  output logic                regwriteW,
  output logic [1:0]          wbselW,
  output logic [4:0]          rdW,
  output logic [31:0]         ALUresW,
  output logic [31:0]         pc4W,
  output logic [31:0]         read_dataW,
  output logic                misalignW,
  output logic                bus_errW,
  output logic [31:0]         resultW
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t      state_q, state_d;

  logic        is_load;
  logic        store_ok;
  logic        access;
  logic        misalign;
  logic        bus_access;
  logic [1:0]  addr_off;
  logic [3:0]  store_be;
  logic [31:0] store_data;
  logic [31:0] rshift;
  logic [31:0] load_data;

  logic        req;
  logic        stall;
  logic        capture;
  logic        timeout;

  logic        regwriteW_q;
  logic [1:0]  wbselW_q;
  logic [4:0]  rdW_q;
  logic [31:0] ALUresW_q;
  logic [31:0] pc4W_q;
  logic [31:0] read_dataW_q;
  logic        misalignW_q;
  logic        bus_errW_q;

  // Decode the access type, misalignment and store lane steering.
  always_comb begin
    addr_off   = ALUresM[1:0];
    is_load    = (wbselM == 2'b01) && !memrwM;
    store_ok   = memrwM && !funct3M[2] && (funct3M[1:0] != 2'b11);
    access     = is_load || store_ok;
    misalign   = access &&
                 (((funct3M[1:0] == 2'b01) && addr_off[0]) ||
                  ((funct3M == 3'b010) && (addr_off != 2'b00)));
    bus_access = access && !misalign;
    store_be   = 4'b0000;
    store_data = data_writeM;
    unique case (funct3M[1:0])
      2'b00: begin
        store_be   = 4'b0001 << addr_off;
        store_data = {4{data_writeM[7:0]}};
      end
      2'b01: begin
        store_be   = 4'b0011 << addr_off;
        store_data = {2{data_writeM[15:0]}};
      end
      2'b10: begin
        store_be   = 4'b1111;
        store_data = data_writeM;
      end
      default: begin
        store_be   = 4'b0000;
        store_data = data_writeM;
      end
    endcase
  end

  // Extract and extend the addressed byte/half/word of the read data.
  always_comb begin
    rshift    = dmem.dmem_rdata >> {addr_off, 3'b000};
    load_data = '0;
    unique case (funct3M)
      3'b000:  load_data = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_data = {{16{rshift[15]}}, rshift[15:0]};
      3'b010:  load_data = dmem.dmem_rdata;
      3'b100:  load_data = {24'h000000, rshift[7:0]};
      3'b101:  load_data = {16'h0000, rshift[15:0]};
      default: load_data = '0;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;

  // Fires on the last allowed WAIT cycle; a same-cycle ack takes priority.
  assign timeout = (state_q == WAIT) && !dmem.dmem_ack &&
                   (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Wait counter advances while the FSM stays in WAIT, clears otherwise.
  always_comb begin
    wait_cnt_d = '0;
    if ((state_q == WAIT) && (state_d == WAIT)) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;

  // The timeout length only matters when the abort logic is built in.
  if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, bus request, stall and MEM/WB capture enable.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    capture = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (bus_access) begin
          req = 1'b1;
          if (!dmem.dmem_ack) begin
            state_d = WAIT;
            stall   = 1'b1;
            capture = 1'b0;
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (dmem.dmem_ack || timeout) begin
          state_d = IDLE;
        end else begin
          stall   = 1'b1;
          capture = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Request and stall drop the moment reset asserts, not at the next edge.
    if (!rst_n) begin
      req   = 1'b0;
      stall = 1'b0;
    end
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req && memrwM;
  assign dmem.dmem_addr  = {ALUresM[31:2], 2'b00};
  assign dmem.dmem_wdata = store_data;
  assign dmem.dmem_be    = store_ok ? store_be : 4'b0000;
  assign stallM          = stall;

  // MEM/WB register: capture on completion, bubble while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwriteW_q  <= 1'b0;
      wbselW_q     <= '0;
      rdW_q        <= '0;
      ALUresW_q    <= '0;
      pc4W_q       <= '0;
      read_dataW_q <= '0;
      misalignW_q  <= 1'b0;
      bus_errW_q   <= 1'b0;
    end else if (capture) begin
      regwriteW_q  <= regwriteM && !misalign && !timeout;
      wbselW_q     <= wbselM;
      rdW_q        <= rdM;
      ALUresW_q    <= ALUresM;
      pc4W_q       <= pc4M;
      read_dataW_q <= load_data;
      misalignW_q  <= misalign;
      bus_errW_q   <= timeout;
    end else begin
      regwriteW_q  <= 1'b0;
      rdW_q        <= '0;
    end
  end

  // Writeback result select.
  always_comb begin
    unique case (wbselW_q)
      2'b01:   resultW = read_dataW_q;
      2'b10:   resultW = pc4W_q;
      default: resultW = ALUresW_q;
    endcase
  end

  assign regwriteW  = regwriteW_q;
  assign wbselW     = wbselW_q;
  assign rdW        = rdW_q;
  assign ALUresW    = ALUresW_q;
  assign pc4W       = pc4W_q;
  assign read_dataW = read_dataW_q;
  assign misalignW  = misalignW_q;
  assign bus_errW   = bus_errW_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: a driver issues instructions and pushes
// the reference-model result; a monitor pops and compares at each MEM/WB
// capture and checks bubbles on stall cycles.
module tb_mem_access;
  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regwriteM, memrwM;
  logic [1:0]  wbselM;
  logic [2:0]  funct3M;
  logic [31:0] ALUresM, data_writeM, pc4M;
  logic [4:0]  rdM;
  logic        stallM, regwriteW, misalignW, bus_errW;
  logic [1:0]  wbselW;
  logic [4:0]  rdW;
  logic [31:0] ALUresW, pc4W, read_dataW, resultW;

  mem_access_if bus();

  mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .regwriteM   (regwriteM),
    .memrwM      (memrwM),
    .wbselM      (wbselM),
    .funct3M     (funct3M),
    .ALUresM     (ALUresM),
    .data_writeM (data_writeM),
    .rdM         (rdM),
    .pc4M        (pc4M),
    .dmem        (bus),
    .stallM      (stallM),
    .regwriteW   (regwriteW),
    .wbselW      (wbselW),
    .rdW         (rdW),
    .ALUresW     (ALUresW),
    .pc4W        (pc4W),
    .read_dataW  (read_dataW),
    .misalignW   (misalignW),
    .bus_errW    (bus_errW),
    .resultW     (resultW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [1:0]  wb;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] ld;
    logic        mis;
    logic        err;
    logic [31:0] res;
    bit          chk_ld;
    bit          chk_res;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   valid_in = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model built from the access rules with plain arithmetic.
  task automatic model(input bit rw, input bit st, input logic [1:0] wb, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                       input logic [4:0] rd, input logic [31:0] pc4, input bit abort,
                       output bit busacc, output logic [3:0] be, output logic [31:0] wd,
                       output exp_t e);
    int unsigned off, size, v;
    bit is_load, sgn, acc, mis;
    off     = a % 4;
    is_load = (wb == 2'd1) && !st;
    size    = 0;
    sgn     = 0;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: if (!st) size = 1;
      3'd5: if (!st) size = 2;
      default: size = 0;
    endcase
    acc    = is_load || (st && size != 0);
    mis    = acc && size > 1 && (off % size) != 0;
    busacc = acc && !mis;
    be     = (st && busacc) ? 4'(((1 << size) - 1) << off) : 4'd0;
    wd     = (size == 1) ? d[7:0] * 32'h0101_0101 :
             (size == 2) ? d[15:0] * 32'h0001_0001 : d;
    v = rdat >> (8 * off);
    if (size == 1) begin
      v = v % 256;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2) begin
      v = v % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else if (size == 4) begin
      v = rdat;
    end else begin
      v = 0;
    end
    e.rw      = rw && !mis && !(busacc && abort);
    e.wb      = wb;
    e.rd      = rd;
    e.alu     = a;
    e.pc4     = pc4;
    e.ld      = v;
    e.mis     = mis;
    e.err     = busacc && abort;
    e.chk_ld  = is_load && busacc && !abort;
    e.res     = (wb == 2'd1) ? v : (wb == 2'd2) ? pc4 : a;
    e.chk_res = (wb != 2'd1) || e.chk_ld;
  endtask

  // Present one instruction, drive the bus side and check bus/stall signals.
  task automatic issue(input bit rw, input bit st, input logic [1:0] wb, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                       input logic [4:0] rd, input logic [31:0] pc4,
                       input int unsigned nwait, input bit abort);
    bit          b;
    logic [3:0]  be;
    logic [31:0] wd;
    exp_t        e;
    model(rw, st, wb, f3, a, d, rdat, rd, pc4, abort, b, be, wd, e);
    @(negedge clk);
    regwriteM = rw; memrwM = st; wbselM = wb; funct3M = f3;
    ALUresM = a; data_writeM = d; rdM = rd; pc4M = pc4;
    bus.dmem_rdata = rdat;
    valid_in = 1'b1;
    sbq.push_back(e);
    if (b) begin
      for (int unsigned c = 0; c <= nwait; c++) begin
        if (c > 0) @(negedge clk);
        bus.dmem_ack = (c == nwait) && !abort;
        #1;
        chk("dmem_req", 32'(bus.dmem_req), 32'd1);
        chk("stallM", 32'(stallM), 32'(c < nwait));
        if (c == 0) begin
          chk("dmem_addr", bus.dmem_addr, a - (a % 4));
          chk("dmem_be", 32'(bus.dmem_be), 32'(be));
          chk("dmem_we", 32'(bus.dmem_we), 32'(st));
          if (st) chk("dmem_wdata", bus.dmem_wdata, wd);
        end
      end
    end else begin
      bus.dmem_ack = 1'($urandom_range(1));
      #1;
      chk("dmem_req_idle", 32'(bus.dmem_req), 32'd0);
      chk("stallM_idle", 32'(stallM), 32'd0);
    end
  endtask

  // Monitor: compare W outputs after each capture edge, bubbles otherwise.
  initial begin
    bit   s, v;
    exp_t e;
    forever begin
      @(posedge clk);
      s = stallM;
      v = valid_in && rst_n;
      #1;
      if (v) begin
        if (s) begin
          chk("bubble_regwriteW", 32'(regwriteW), 32'd0);
          chk("bubble_rdW", 32'(rdW), 32'd0);
        end else if (sbq.size() == 0) begin
          chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("regwriteW", 32'(regwriteW), 32'(e.rw));
          chk("wbselW", 32'(wbselW), 32'(e.wb));
          chk("rdW", 32'(rdW), 32'(e.rd));
          chk("ALUresW", ALUresW, e.alu);
          chk("pc4W", pc4W, e.pc4);
          chk("misalignW", 32'(misalignW), 32'(e.mis));
          chk("bus_errW", 32'(bus_errW), 32'(e.err));
          if (e.chk_ld) chk("read_dataW", read_dataW, e.ld);
          if (e.chk_res) chk("resultW", resultW, e.res);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    regwriteM = 0; memrwM = 0; wbselM = '0; funct3M = '0;
    ALUresM = '0; data_writeM = '0; rdM = '0; pc4M = '0;
    bus.dmem_rdata = '0; bus.dmem_ack = 1'b0;
    #12;
    chk("rst_resultW", resultW, 32'd0);
    chk("rst_regwriteW", 32'(regwriteW), 32'd0);
    chk("rst_misalignW", 32'(misalignW), 32'd0);
    chk("rst_bus_errW", 32'(bus_errW), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // LB from 0x1003, zero-wait ack: sign-extended 0x80.
    issue(1, 0, 2'b01, 3'b000, 32'h1003, 32'h0, 32'h80FF_FF12, 5'd3, 32'h10, 0, 0);
    // SH 0xABCD to 0x2002, three wait cycles.
    issue(0, 1, 2'b00, 3'b001, 32'h2002, 32'h0000_ABCD, 32'h0, 5'd0, 32'h14, 3, 0);
    // Misaligned LW.
    issue(1, 0, 2'b01, 3'b010, 32'h3001, 32'h0, 32'h1234_5678, 5'd7, 32'h18, 0, 0);
    // Non-access pc+4 writeback.
    issue(1, 0, 2'b10, 3'b000, 32'h55, 32'h0, 32'h0, 5'd9, 32'h104, 0, 0);

    // Reset in the middle of a WAIT, then a late ack.
    @(negedge clk);
    valid_in = 1'b0;
    regwriteM = 1; memrwM = 0; wbselM = 2'b01; funct3M = 3'b010;
    ALUresM = 32'h40; rdM = 5'd4; bus.dmem_ack = 1'b0;
    #1;
    chk("pre_rst_stall", 32'(stallM), 32'd1);
    @(negedge clk);
    #1;
    chk("pre_rst_wait_req", 32'(bus.dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_mid_stall", 32'(stallM), 32'd0);
    chk("rst_mid_resultW", resultW, 32'd0);
    chk("rst_mid_pc4W", pc4W, 32'd0);
    regwriteM = 0; memrwM = 0; wbselM = '0; funct3M = '0;
    ALUresM = '0; rdM = '0; pc4M = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.dmem_ack = 1'b1;
    #1;
    chk("late_ack_req", 32'(bus.dmem_req), 32'd0);
    chk("late_ack_stall", 32'(stallM), 32'd0);
    issue(1, 0, 2'b01, 3'b010, 32'h80, 32'h0, 32'hCAFE_F00D, 5'd11, 32'h20, 1, 0);

`ifdef MEM_TIMEOUT_EN
    // No ack: abort on the last WAIT cycle. Then ack exactly on that cycle.
    issue(1, 0, 2'b01, 3'b010, 32'h100, 32'h0, 32'h1111_2222, 5'd12, 32'h24, TMO, 1);
    issue(1, 0, 2'b01, 3'b010, 32'h104, 32'h0, 32'h3333_4444, 5'd13, 32'h28, TMO, 0);
`endif

    // Randomized mix of loads, stores and non-access instructions.
    for (int i = 0; i < 300; i++) begin
      int unsigned k;
      logic [1:0]  wb;
      bit          st;
      k = $urandom_range(2);
      if (k == 0) begin
        st = 0; wb = 2'b01;
      end else if (k == 1) begin
        st = 1; wb = 2'($urandom_range(3));
      end else begin
        st = 0;
        wb = 2'($urandom_range(2));
        if (wb == 2'b01) wb = 2'b11;
      end
      issue(1'($urandom_range(1)), st, wb, 3'($urandom_range(7)), $urandom, $urandom,
            $urandom, 5'($urandom_range(31)), $urandom, $urandom_range(3), 0);
    end

    @(negedge clk);
    valid_in = 1'b0;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
